ps2_keyboard_tx: RTL and testbench
==================================

Name: ps2_keyboard_tx

Overview:
Device-side PS/2 keyboard transmitter. It emulates a keyboard so the top level can feed scancodes into the orao core's ps2clk/ps2data inputs, which are currently tied high. Bytes are queued through a small FIFO and serialised as standard 11-bit PS/2 frames on open-drain clock/data lines. Host clock-inhibit is honoured with abort and retry.

Parameters:
clk_mhz, 25, system clock frequency in MHz
ps2_khz, 10, PS/2 clock rate; half period HALF = clk_mhz*500/ps2_khz cycles (1250 at defaults)
gap_cycles, 5000, idle cycles with both lines released after each stop bit
fifo_depth, 4, byte FIFO entries (power of 2, minimum 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
in_data  input  8  scancode byte to send
in_valid  input  1  push request; accepted when in_valid & in_ready
in_ready  output  1  FIFO not full
ps2clk_in  input  1  sensed level of the PS/2 clock line
ps2data_in  input  1  sensed level of the PS/2 data line
ps2clk_oe  output  1  1 = pull clock line low, 0 = release
ps2data_oe  output  1  1 = pull data line low, 0 = release
busy  output  1  state is not IDLE, or FIFO not empty
aborted  output  1  one-cycle pulse when a frame is aborted by host inhibit

Behaviour:
- Reset (sync, high): FIFO emptied, state IDLE, ps2clk_oe=0, ps2data_oe=0, busy=0, aborted=0, in_ready=0 while reset is high and 1 the cycle after. Reset mid-frame releases both lines on the next edge; the partial byte is discarded.
- FIFO:
  - Push when in_valid & in_ready.
  - in_ready is registered from the count: 0 when count==fifo_depth. A push while full is ignored.
  - The head entry stays in the FIFO during transmission. It is popped only after the stop-bit low phase completes, so the transmitting byte counts toward full.
  - Push and pop in the same cycle are both honoured.
- Frame bits, idx 0..10: start 0, data[0]..data[7] LSB first, odd parity (= ~^data), stop 1.
- Line encoding: ps2data_oe = ~bit.
- States:
  - IDLE:
    - Lines released.
    - If FIFO not empty and ps2clk_in=1 and ps2data_in=1: go to BIT_HIGH with idx=0 and cnt=0. ps2data_oe=1 in the same edge.
    - A host holding either line low keeps the block in IDLE. Host request-to-send is not supported and is ignored.
  - BIT_HIGH:
    - Clock released, data holds the current bit, cnt counts HALF cycles.
    - On the last cycle, if ps2clk_in=0 and idx<10: abort. Release both lines, pulse aborted, go to INHIBIT. The head byte is retained.
    - Otherwise go to BIT_LOW with cnt=0.
  - BIT_LOW:
    - ps2clk_oe=1 for HALF cycles, data unchanged.
    - At the end, release the clock.
    - If idx<10: idx+1, load the next bit onto data, go to BIT_HIGH.
    - If idx=10: pop, release data, go to GAP.
  - GAP: both lines released for gap_cycles, then IDLE.
  - INHIBIT:
    - Both lines released.
    - Counts consecutive cycles with ps2clk_in=1; the count is cleared whenever ps2clk_in=0.
    - After 2*HALF consecutive high cycles, go to IDLE. The same byte is retransmitted from the start bit.
- Inhibit during idx=10 (stop bit) is ignored; the frame counts as sent.
- Timing: frame length = 22*HALF cycles from the IDLE exit edge to the GAP entry edge. Exactly 11 ps2clk_oe pulses, each HALF cycles long.
- Counters are wide enough for max(HALF*2, gap_cycles). No wrap-around within a state.

Test Plan:
- Push 0x1C, ps2 lines pulled up:
  - 11 clock-low pulses of 1250 cycles each.
  - Data sampled at each falling edge = 0,0,0,1,1,1,0,0,0,0(parity),1.
  - aborted never asserted.
  - busy falls gap_cycles after the last clock release.
- Push 0x5A:
  - Data bits = 0,1,0,1,1,0,1,0.
  - Parity bit = 1 (4 ones).
  - Frame length exactly 22*1250 cycles.
- Push 5 bytes back-to-back with in_valid held:
  - in_ready drops after the 4th accept.
  - The 5th is accepted one cycle after the first frame's pop.
  - Frames appear in order, separated by a ≥5000-cycle idle gap.
- Host pulls ps2clk_in low during BIT_HIGH of idx=4, holds it 3000 cycles, then releases:
  - aborted pulses once.
  - Both lines are released within 1 cycle of the abort.
  - The same byte restarts with its start bit 2500 cycles after release.
- Assert reset during the BIT_LOW of idx=6:
  - Next edge: ps2clk_oe=0, ps2data_oe=0, busy=0.
  - After reset, no frame is sent until a new push.
- Hold ps2data_in=0 with the FIFO non-empty: the block stays in IDLE with lines released, and starts within 1 cycle after the line is released.

Source files
------------

// File: rtl/ps2_keyboard_tx_if.sv
// Byte push handshake into the PS/2 keyboard transmitter.
// The producer side is the master; the transmitter FIFO is the slave.
interface ps2_keyboard_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 keyboard transmitter: byte FIFO feeding 11-bit
// open-drain frames, with abort and retry on host clock inhibit.
module ps2_keyboard_tx #(
  parameter int clk_mhz    = 25,
  parameter int ps2_khz    = 10,
  parameter int gap_cycles = 5000,
  parameter int fifo_depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  ps2_keyboard_tx_if.slave bus,
  input  logic             ps2clk_in,
  input  logic             ps2data_in,
  output logic             ps2clk_oe,
  output logic             ps2data_oe,
  output logic             busy,
  output logic             aborted
);

  localparam int HALF = clk_mhz * 500 / ps2_khz;
  localparam int CMAX = (2 * HALF > gap_cycles) ? 2 * HALF : gap_cycles;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int AW   = $clog2(fifo_depth);
  localparam int NW   = AW + 1;

  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] INH_END  = CW'(2 * HALF - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(gap_cycles - 1);
  localparam logic [NW-1:0] FULL     = NW'(fifo_depth);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] BIT_HIGH = 3'd1;
  localparam logic [2:0] BIT_LOW  = 3'd2;
  localparam logic [2:0] GAP      = 3'd3;
  localparam logic [2:0] INHIBIT  = 3'd4;

  logic [7:0]    mem [fifo_depth];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [NW-1:0] count;
  logic [NW-1:0] count_nx;
  logic          push;
  logic          pop;

  logic [2:0]    state;
  logic [3:0]    idx;
  logic [CW-1:0] cnt;
  logic [10:0]   frame;
  logic          half_done;
  logic          last_bit;

  assign half_done = cnt == HALF_END;
  assign last_bit  = idx == 4'd10;
  assign push      = bus.in_valid & bus.in_ready;
  // Head leaves the FIFO only once the stop bit has been clocked out.
  assign pop       = (state == BIT_LOW) & half_done & last_bit;
  assign count_nx  = count + NW'(push) - NW'(pop);
  assign frame     = {1'b1, ~^mem[rp], mem[rp], 1'b0};
  assign busy      = (state != IDLE) | (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp           <= '0;
      rp           <= '0;
      count        <= '0;
      bus.in_ready <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      count        <= count_nx;
      bus.in_ready <= count_nx != FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      ps2clk_oe  <= 1'b0;
      ps2data_oe <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      aborted <= 1'b0;
      unique case (state)
        IDLE: begin
          if (count != '0 && ps2clk_in && ps2data_in) begin
            state      <= BIT_HIGH;
            idx        <= '0;
            cnt        <= '0;
            ps2data_oe <= 1'b1;
          end
        end
        BIT_HIGH: begin
          if (!half_done) begin
            cnt <= cnt + 1'b1;
          end else if (!ps2clk_in && !last_bit) begin
            state      <= INHIBIT;
            cnt        <= '0;
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            aborted    <= 1'b1;
          end else begin
            state     <= BIT_LOW;
            cnt       <= '0;
            ps2clk_oe <= 1'b1;
          end
        end
        BIT_LOW: begin
          if (!half_done) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt       <= '0;
            ps2clk_oe <= 1'b0;
            if (!last_bit) begin
              idx        <= idx + 4'd1;
              ps2data_oe <= ~frame[idx + 4'd1];
              state      <= BIT_HIGH;
            end else begin
              ps2data_oe <= 1'b0;
              state      <= GAP;
            end
          end
        end
        GAP: begin
          if (cnt == GAP_END) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        INHIBIT: begin
          // Needs an unbroken run of released-clock cycles.
          if (!ps2clk_in) begin
            cnt <= '0;
          end else if (cnt == INH_END) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          ps2clk_oe  <= 1'b0;
          ps2data_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Bench for ps2_keyboard_tx: a line-level host monitor decodes frames
// and compares them against a queue of accepted bytes.
module tb_ps2_keyboard_tx;

  localparam int H     = 10;
  localparam int G     = 40;
  localparam int D     = 4;
  localparam int FRAME = 22 * H;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic host_clk = 1'b0;
  logic host_data = 1'b0;
  logic ps2clk_in;
  logic ps2data_in;
  logic ps2clk_oe;
  logic ps2data_oe;
  logic busy;
  logic aborted;

  ps2_keyboard_tx_if bus();

  assign ps2clk_in  = ~ps2clk_oe & ~host_clk;
  assign ps2data_in = ~ps2data_oe & ~host_data;

  ps2_keyboard_tx #(
    .clk_mhz(1),
    .ps2_khz(50),
    .gap_cycles(G),
    .fifo_depth(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .ps2clk_in(ps2clk_in),
    .ps2data_in(ps2data_in),
    .ps2clk_oe(ps2clk_oe),
    .ps2data_oe(ps2data_oe),
    .busy(busy),
    .aborted(aborted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] ps2_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    f = '0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i + 1] = b[i];
      ones += int'(b[i]);
    end
    f[9] = (ones % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction

  logic [7:0]  exp_q[$];
  int          starts = 0;
  int          frames = 0;
  int          abort_cnt = 0;
  int          nbits = 0;
  int          start_edge = 0;
  int          end_edge = 0;
  int          rise_edge = 0;
  bit          in_frame = 0;
  bit          have_end = 0;
  logic [10:0] word = '0;
  logic [10:0] last_word = '0;
  logic [7:0]  mon_b;
  logic        pc = 1'b0;
  logic        pd = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      in_frame = 0;
      nbits = 0;
    end else if (aborted) begin
      abort_cnt++;
      chk("abort_rel", {ps2clk_oe, ps2data_oe}, 0);
      in_frame = 0;
      nbits = 0;
    end else begin
      if (!in_frame && !pd && ps2data_oe) begin
        in_frame = 1;
        nbits = 0;
        starts++;
        start_edge = cyc;
        if (have_end) chk("gap_ok", longint'(cyc - end_edge >= G), 1);
      end
      if (in_frame && !pc && ps2clk_oe) begin
        word[nbits] = ~ps2data_oe;
        rise_edge = cyc;
      end
      if (in_frame && pc && !ps2clk_oe) begin
        chk("pulse", cyc - rise_edge, H);
        nbits++;
        if (nbits == 11) begin
          in_frame = 0;
          frames++;
          end_edge = cyc;
          have_end = 1;
          last_word = word;
          chk("len", cyc - start_edge, FRAME);
          if (exp_q.size() == 0) begin
            chk("spurious", 1, 0);
          end else begin
            mon_b = exp_q.pop_front();
            chk("frame", word, ps2_frame(mon_b));
          end
        end
      end
    end
    pc = ps2clk_oe;
    pd = ps2data_oe;
  end

  task automatic push(input logic [7:0] b, input bit hold, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    bus.in_data = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    acc = cyc + 1;
    if (bus.in_ready) exp_q.push_back(b);
    else chk("push_to", 0, 1);
    @(posedge clk);
    #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames < n && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (frames < n) chk("frame_to", frames, n);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("idle_to", 1, 0);
  endtask

  initial begin
    int acc;
    int r;
    int f0;
    int s0;
    int a0;
    int t;
    logic [7:0] b;

    bus.in_data = '0;
    bus.in_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_oe", {ps2clk_oe, ps2data_oe}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_abort", aborted, 0);
    chk("rst_rdy", bus.in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rdy_after", bus.in_ready, 1);

    push(8'h1C, 0, acc);
    wait_frames(1);
    chk("f1c", last_word, 11'h438);
    wait_idle();
    chk("busy_fall", cyc - end_edge, G);
    chk("no_abort", abort_cnt, 0);

    push(8'h5A, 0, acc);
    wait_frames(2);
    chk("f5a", last_word, 11'h6B4);
    wait_idle();

    f0 = frames;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      push(b, i < 4, acc);
      if (i == 3) chk("full", bus.in_ready, 0);
      if (i == 4) begin
        chk("acc5_pop", frames - f0, 1);
        chk("acc5", acc - end_edge, 1);
      end
    end
    wait_frames(f0 + 5);
    wait_idle();

    f0 = frames;
    for (int i = 0; i < 6; i++) begin
      push(8'($urandom), 0, acc);
      repeat ($urandom_range(0, 300)) @(negedge clk);
    end
    wait_frames(f0 + 6);
    wait_idle();

    a0 = abort_cnt;
    f0 = frames;
    push(8'($urandom), 0, acc);
    t = 0;
    while (!(in_frame && nbits == 4 && !ps2clk_oe) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk("bit4_to", 0, 1);
    host_clk = 1'b1;
    repeat (300) @(negedge clk);
    chk("abort_once", abort_cnt - a0, 1);
    s0 = starts;
    host_clk = 1'b0;
    r = cyc;
    t = 0;
    while (starts == s0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("restart", start_edge - (r + 1), 2 * H);
    wait_frames(f0 + 1);
    wait_idle();
    chk("abort_total", abort_cnt - a0, 1);

    f0 = frames;
    host_data = 1'b1;
    s0 = starts;
    push(8'($urandom), 0, acc);
    repeat (50) @(negedge clk);
    chk("hold_oe", {ps2clk_oe, ps2data_oe}, 0);
    chk("hold_busy", busy, 1);
    chk("hold_nostart", starts, s0);
    host_data = 1'b0;
    r = cyc;
    t = 0;
    while (starts == s0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("hold_start", start_edge - r, 1);
    wait_frames(f0 + 1);
    wait_idle();

    push(8'($urandom), 0, acc);
    t = 0;
    while (!(in_frame && nbits == 6 && ps2clk_oe) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk("bit6_to", 0, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_oe", {ps2clk_oe, ps2data_oe}, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    s0 = starts;
    repeat (3 * (FRAME + G)) @(negedge clk);
    chk("no_frame", starts, s0);
    chk("rdy_back", bus.in_ready, 1);
    chk("idle_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
